// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: control inputs, byte-wide memory read port and decoder-side instruction handshake.
interface instr_fetch_if;
    logic        step;
    logic        pc_load;
    logic [15:0] pc_new;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] pc_out;
    logic        fault;

    modport master (
        input  step, pc_load, pc_new, mem_rdata, instr_ready,
        output mem_addr, mem_rd, instr, instr_valid, pc_out, fault
    );

    modport slave (
        output step, pc_load, pc_new, mem_rdata, instr_ready,
        input  mem_addr, mem_rd, instr, instr_valid, pc_out, fault
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: assembles 16-bit little-endian instructions from a byte-wide memory
// using a Moore FSM, with redirect, backpressure and a sticky odd-address fault.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic            clk,
    input logic            rst_n,
    instr_fetch_if.master  bus
);

    typedef enum logic [2:0] {StIdle, StLo, StHi, StWait, StValid} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic [15:0] instr_q, instr_d;
    logic        fault_q, fault_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            pc_out_q <= RESET_PC;
            instr_q  <= 16'h0000;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            fault_q  <= fault_d;
        end
    end

    // A redirect beats everything, including a handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        if (bus.pc_load) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (bus.step) state_d = StLo;
                StLo:    state_d = StHi;
                StHi:    state_d = StWait;
                StWait:  state_d = StValid;
                StValid: if (bus.instr_ready) state_d = bus.step ? StLo : StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        fault_d  = fault_q;
        if (bus.pc_load) begin
            pc_d    = {bus.pc_new[15:1], 1'b0};
            fault_d = fault_q | bus.pc_new[0];
        end else begin
            unique case (state_q)
                StHi:    instr_d[7:0] = bus.mem_rdata;
                StWait: begin
                    instr_d[15:8] = bus.mem_rdata;
                    pc_out_d      = pc_q;
                end
                StValid: if (bus.instr_ready) pc_d = pc_q + 16'd2;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mem_rd      = (state_q == StLo) || (state_q == StHi);
        bus.mem_addr    = (state_q == StHi) ? pc_q + 16'd1 : pc_q;
        bus.instr_valid = (state_q == StValid);
        bus.instr       = instr_q;
        bus.pc_out      = pc_out_q;
        bus.fault       = fault_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run against a
// transaction-level model of the PC sequence and memory contents.
module tb_instr_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   fails = 0;

    logic [7:0] mem [0:65535];

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Byte memory with one-cycle read latency; garbage when not read.
    always @(posedge clk) bus.mem_rdata <= bus.mem_rd ? mem[bus.mem_addr] : 8'($urandom);

    function automatic logic [50:0] snap();
        return {bus.instr_valid, bus.mem_rd, bus.fault, bus.mem_addr, bus.instr, bus.pc_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.step = 1'b0;
        bus.pc_load = 1'b0;
        bus.pc_new = 16'h0000;
        bus.instr_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [50:0] exp;
        rst_n = 1'b0;
        bus.step = 1'b1;
        bus.pc_load = 1'b1;
        bus.pc_new = 16'h1235;
        bus.instr_ready = 1'b1;
        tick();
        exp = {1'b0, 1'b0, 1'b0, RESET_PC, 16'h0000, RESET_PC};
        tests_run++;
        if (snap() !== exp) begin
            fails++;
            $display("FAIL reset_state: got %h expected %h", snap(), exp);
        end
        rst_n = 1'b1;
        bus.step = 1'b0;
        bus.pc_load = 1'b0;
        bus.instr_ready = 1'b0;
        tick();
        tests_run++;
        if ({bus.instr_valid, bus.mem_rd, bus.mem_addr} !== {2'b00, RESET_PC}) begin
            fails++;
            $display("FAIL reset_idle: got %b%b %h expected 00 %h",
                     bus.instr_valid, bus.mem_rd, bus.mem_addr, RESET_PC);
        end
    endtask

    task automatic test_basic_fetch();
        logic [50:0] exp;
        do_reset();
        mem[16'h0000] = 8'h34;
        mem[16'h0001] = 8'h12;
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        tests_run++;
        if ({bus.instr_valid, bus.mem_rd, bus.mem_addr} !== {2'b01, 16'h0000}) begin
            fails++;
            $display("FAIL basic_lo: got %b%b %h expected 01 0000",
                     bus.instr_valid, bus.mem_rd, bus.mem_addr);
        end
        tick();
        tests_run++;
        if ({bus.instr_valid, bus.mem_rd, bus.mem_addr} !== {2'b01, 16'h0001}) begin
            fails++;
            $display("FAIL basic_hi: got %b%b %h expected 01 0001",
                     bus.instr_valid, bus.mem_rd, bus.mem_addr);
        end
        tick();
        tests_run++;
        if ({bus.instr_valid, bus.mem_rd} !== 2'b00) begin
            fails++;
            $display("FAIL basic_wait: got %b%b expected 00", bus.instr_valid, bus.mem_rd);
        end
        tick();
        exp = {1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000};
        tests_run++;
        if (snap() !== exp) begin
            fails++;
            $display("FAIL basic_valid: got %h expected %h", snap(), exp);
        end
    endtask

    // Continues from the VALID state left by test_basic_fetch.
    task automatic test_backpressure();
        logic [50:0] exp;
        exp = {1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000};
        bus.instr_ready = 1'b0;
        bus.step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (snap() !== exp) begin
                fails++;
                $display("FAIL backpressure_hold%0d: got %h expected %h", i, snap(), exp);
            end
        end
        bus.step = 1'b0;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        tests_run++;
        if ({bus.instr_valid, bus.mem_rd, bus.mem_addr} !== {2'b00, 16'h0002}) begin
            fails++;
            $display("FAIL backpressure_release: got %b%b %h expected 00 0002",
                     bus.instr_valid, bus.mem_rd, bus.mem_addr);
        end
    endtask

    task automatic test_back_to_back();
        int          cyc [2];
        logic [15:0] ins [2];
        logic [15:0] pcs [2];
        int          n;
        do_reset();
        mem[16'h0000] = 8'h34;
        mem[16'h0001] = 8'h12;
        mem[16'h0002] = 8'h78;
        mem[16'h0003] = 8'h56;
        bus.step = 1'b1;
        bus.instr_ready = 1'b1;
        n = 0;
        for (int c = 1; c <= 20 && n < 2; c++) begin
            tick();
            if (bus.instr_valid === 1'b1) begin
                cyc[n] = c;
                ins[n] = bus.instr;
                pcs[n] = bus.pc_out;
                n++;
            end
        end
        bus.step = 1'b0;
        bus.instr_ready = 1'b0;
        tests_run++;
        if (n !== 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d instructions expected 2 within 20 cycles", n);
        end else begin
            tests_run++;
            if ({ins[0], pcs[0]} !== {16'h1234, 16'h0000}) begin
                fails++;
                $display("FAIL b2b_first: got %h@%h expected 1234@0000", ins[0], pcs[0]);
            end
            tests_run++;
            if ({ins[1], pcs[1]} !== {16'h5678, 16'h0002}) begin
                fails++;
                $display("FAIL b2b_second: got %h@%h expected 5678@0002", ins[1], pcs[1]);
            end
            tests_run++;
            if (cyc[0] !== 4 || cyc[1] - cyc[0] !== 4) begin
                fails++;
                $display("FAIL b2b_timing: got cycles %0d,%0d expected 4,8", cyc[0], cyc[1]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] addrs [$];
        bit          seen;
        do_reset();
        mem[16'hFFFE] = 8'hCD;
        mem[16'hFFFF] = 8'hAB;
        bus.pc_load = 1'b1;
        bus.pc_new = 16'hFFFE;
        tick();
        bus.pc_load = 1'b0;
        tests_run++;
        if ({bus.mem_rd, bus.fault, bus.mem_addr} !== {2'b00, 16'hFFFE}) begin
            fails++;
            $display("FAIL wrap_load: got %b%b %h expected 00 fffe",
                     bus.mem_rd, bus.fault, bus.mem_addr);
        end
        bus.step = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (bus.mem_rd === 1'b1) addrs.push_back(bus.mem_addr);
            if (bus.instr_valid === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            fails++;
            $display("FAIL wrap_timeout: got no instr_valid expected one within 10 cycles");
        end
        tests_run++;
        if (addrs.size() !== 2 || addrs[0] !== 16'hFFFE || addrs[1] !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_reads: got %0d reads expected fffe,ffff", addrs.size());
        end
        tests_run++;
        if ({bus.instr, bus.pc_out} !== {16'hABCD, 16'hFFFE}) begin
            fails++;
            $display("FAIL wrap_instr: got %h@%h expected abcd@fffe", bus.instr, bus.pc_out);
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        bus.step = 1'b0;
        tests_run++;
        if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0000}) begin
            fails++;
            $display("FAIL wrap_next: got %b %h expected 1 0000", bus.mem_rd, bus.mem_addr);
        end
    endtask

    task automatic test_odd_redirect();
        do_reset();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        tick();
        tests_run++;
        if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 16'h0001}) begin
            fails++;
            $display("FAIL odd_in_hi: got %b %h expected 1 0001", bus.mem_rd, bus.mem_addr);
        end
        bus.pc_load = 1'b1;
        bus.pc_new = 16'h0103;
        tick();
        bus.pc_load = 1'b0;
        tests_run++;
        if ({bus.instr_valid, bus.mem_rd, bus.fault, bus.mem_addr} !== {3'b001, 16'h0102}) begin
            fails++;
            $display("FAIL odd_abort: got %b%b%b %h expected 001 0102",
                     bus.instr_valid, bus.mem_rd, bus.fault, bus.mem_addr);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if ({bus.instr_valid, bus.fault} !== 2'b01) begin
                fails++;
                $display("FAIL odd_hold%0d: got valid=%b fault=%b expected valid=0 fault=1",
                         i, bus.instr_valid, bus.fault);
            end
        end
        mem[16'h0102] = 8'h11;
        mem[16'h0103] = 8'h22;
        bus.step = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.step = 1'b0;
        tests_run++;
        if ({bus.instr_valid, bus.fault, bus.instr, bus.pc_out} !== {2'b11, 16'h2211, 16'h0102}) begin
            fails++;
            $display("FAIL odd_refetch: got %b%b %h@%h expected 11 2211@0102",
                     bus.instr_valid, bus.fault, bus.instr, bus.pc_out);
        end
        do_reset();
        tests_run++;
        if (bus.fault !== 1'b0) begin
            fails++;
            $display("FAIL odd_reset_clears: got fault=%b expected 0", bus.fault);
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [50:0] exp;
        do_reset();
        mem[16'h0000] = 8'h5A;
        mem[16'h0001] = 8'hA5;
        bus.step = 1'b1;
        tick();
        tick();
        tick();
        tests_run++;
        if ({bus.instr_valid, bus.mem_rd, bus.instr[7:0]} !== {2'b00, 8'h5A}) begin
            fails++;
            $display("FAIL midreset_wait: got %b%b %h expected 00 5a",
                     bus.instr_valid, bus.mem_rd, bus.instr[7:0]);
        end
        rst_n = 1'b0;
        bus.pc_load = 1'b1;
        bus.pc_new = 16'h4445;
        tick();
        exp = {1'b0, 1'b0, 1'b0, RESET_PC, 16'h0000, RESET_PC};
        tests_run++;
        if (snap() !== exp) begin
            fails++;
            $display("FAIL midreset_state: got %h expected %h", snap(), exp);
        end
        rst_n = 1'b1;
        bus.pc_load = 1'b0;
        bus.step = 1'b0;
    endtask

    // Model: PC advances by 2 per accepted handshake, redirects replace it, every delivered
    // instruction must equal the two memory bytes at the model PC.
    task automatic test_random();
        logic [15:0] pc_exp;
        logic        fault_exp;
        int          handshakes;
        do_reset();
        pc_exp = RESET_PC;
        fault_exp = 1'b0;
        handshakes = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.step = ($urandom_range(0, 3) != 0);
            bus.instr_ready = ($urandom_range(0, 2) != 0);
            bus.pc_load = ($urandom_range(0, 24) == 0);
            bus.pc_new = 16'($urandom);
            tests_run++;
            if (bus.fault !== fault_exp) begin
                fails++;
                $display("FAIL rand_fault c%0d: got %b expected %b", c, bus.fault, fault_exp);
            end
            if (bus.mem_rd === 1'b1) begin
                tests_run++;
                if (bus.mem_addr !== pc_exp && bus.mem_addr !== pc_exp + 16'd1) begin
                    fails++;
                    $display("FAIL rand_addr c%0d: got %h expected %h or next",
                             c, bus.mem_addr, pc_exp);
                end
            end
            if (bus.instr_valid === 1'b1) begin
                tests_run++;
                if ({bus.instr, bus.pc_out} !== {mem[pc_exp + 16'd1], mem[pc_exp], pc_exp}) begin
                    fails++;
                    $display("FAIL rand_instr c%0d: got %h@%h expected %h%h@%h", c, bus.instr,
                             bus.pc_out, mem[pc_exp + 16'd1], mem[pc_exp], pc_exp);
                end
            end
            if (bus.pc_load) begin
                pc_exp = {bus.pc_new[15:1], 1'b0};
                fault_exp = fault_exp | bus.pc_new[0];
            end else if (bus.instr_valid === 1'b1 && bus.instr_ready) begin
                pc_exp = pc_exp + 16'd2;
                handshakes++;
            end
            tick();
        end
        bus.step = 1'b0;
        bus.pc_load = 1'b0;
        bus.instr_ready = 1'b0;
        tests_run++;
        if (handshakes < 100) begin
            fails++;
            $display("FAIL rand_progress: got %0d handshakes expected at least 100", handshakes);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_odd_redirect();
        test_reset_mid_fetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
